clken_rst_seq: RTL and testbench

//  Synthesizable, parametrised successor of the bench clock/reset generator. Runs on one clock and produces
//  NCH staged per-channel resets, plus per-channel divided clock-enable pulses with a pause input and an

---
 rtl/clken_rst_seq_pkg.sv | 25 ++
 rtl/clken_rst_seq_div_chan.sv | 92 +++++++++
 rtl/clken_rst_seq.sv | 119 +++++++++++
 tb/tb_clken_rst_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/clken_rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// clken_rst_pkg
//   Shared types and helpers for the staged reset / clock-enable generator.
//   - seq_state_t : sequencer FSM encoding (hold, staged release, run)
//   - CNT_W_DEF   : default width of divider and pulse counters
//   - NCH_MAX     : largest supported channel count
//   - stage_cycle : cycle number (counted from reset release) at which a
//                   given channel's reset lifts
// ---------------------------------------------------------------------------
package clken_rst_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_STAGE,
        S_RUN
    } seq_state_t;

    localparam int CNT_W_DEF = 16;
    localparam int NCH_MAX   = 16;

    function automatic int stage_cycle(input int idx, input int rst_hold, input int stage_gap);
        return rst_hold + idx * stage_gap;
    endfunction

endpackage

// File: rtl/clken_rst_seq_div_chan.sv
// ---------------------------------------------------------------------------
// clken_div_chan
//   One channel of the clock-enable generator. On the edge where the channel
//   leaves reset it latches its divide ratio, then emits a one-cycle enable
//   every D unpaused cycles. With PERIOD_CNT > 0 it stops after that many
//   pulses and raises a sticky done flag.
// Ports
//   clock        in  system clock, rising edge
//   rst_x        in  synchronous reset, active-high
//   chan_release in  single-cycle strobe on the channel's reset-release edge
//   pause        in  1 freezes the divider and pulse counter
//   div          in  divide ratio, sampled only on chan_release (0 means 1)
//   ce           out registered one-cycle clock-enable pulse
//   done         out sticky, set on the edge of the PERIOD_CNT-th pulse
// ---------------------------------------------------------------------------
module clken_div_chan #(
    parameter int CNT_W      = 16,
    parameter int PERIOD_CNT = 0
) (
    input  logic             clock,
    input  logic             rst_x,
    input  logic             chan_release,
    input  logic             pause,
    input  logic [CNT_W-1:0] div,
    output logic             ce,
    output logic             done
);

    localparam logic [CNT_W-1:0] PC_LIM = CNT_W'(PERIOD_CNT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic             run_q,       run_d;
    logic [CNT_W-1:0] div_q,       div_d;
    logic [CNT_W-1:0] div_cnt_q,   div_cnt_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             ce_q,        ce_d;
    logic             done_q,      done_d;

    always_comb begin
        run_d       = run_q;
        div_d       = div_q;
        div_cnt_d   = div_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        ce_d        = 1'b0;
        done_d      = done_q;
        if (chan_release) begin
            run_d     = 1'b1;
            div_d     = (div == '0) ? CNT_W'(1) : div;
            div_cnt_d = '0;
        end else if (run_q && !pause && !done_q) begin
            // A paused wrap is simply deferred: the count holds at D-1, so
            // the first unpaused edge produces the pulse.
            if (div_cnt_q == div_q - CNT_W'(1)) begin
                div_cnt_d = '0;
                ce_d      = 1'b1;
                if (PERIOD_CNT != 0) begin
                    pulse_cnt_d = sat_inc(pulse_cnt_q);
                    if (pulse_cnt_d == PC_LIM) begin
                        done_d = 1'b1;
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst_x) begin
            run_q       <= 1'b0;
            div_q       <= CNT_W'(1);
            div_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            ce_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            run_q       <= run_d;
            div_q       <= div_d;
            div_cnt_q   <= div_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            ce_q        <= ce_d;
            done_q      <= done_d;
        end
    end

    assign ce   = ce_q;
    assign done = done_q;

endmodule

// File: rtl/clken_rst_seq.sv
// ---------------------------------------------------------------------------
// clken_rst_seq
//   Staged reset sequencer with per-channel divided clock enables.
//   Channel 0 leaves reset RST_HOLD cycles after rst_x drops; channel i
//   follows STAGE_GAP cycles after channel i-1. Each released channel then
//   runs its own clken_div_chan.
// Ports
//   clock    in   system clock, rising edge
//   rst_x    in   synchronous reset, active-high, overrides everything
//   pause    in   freezes all dividers / pulse counters (sequencer runs on)
//   cfg_div  in   per-channel divide ratio, channel i = [i*CNT_W +: CNT_W]
//   ch_rst   out  per-channel reset, level ACTIVE while asserted
//   ch_ce    out  per-channel one-cycle clock-enable pulse
//   ch_done  out  channel has issued PERIOD_CNT pulses (sticky)
//   seq_busy out  1 until every channel has left reset
//   done     out  all channels done; constant 0 when PERIOD_CNT == 0
// ---------------------------------------------------------------------------
module clken_rst_seq
    import clken_rst_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int RST_HOLD   = 5,
    parameter int STAGE_GAP  = 2,
    parameter int PERIOD_CNT = 0,
    parameter int ACTIVE     = 1
) (
    input  logic                 clock,
    input  logic                 rst_x,
    input  logic                 pause,
    input  logic [NCH*CNT_W-1:0] cfg_div,
    output logic [NCH-1:0]       ch_rst,
    output logic [NCH-1:0]       ch_ce,
    output logic [NCH-1:0]       ch_done,
    output logic                 seq_busy,
    output logic                 done
);

    localparam int LAST_CYC = stage_cycle(NCH - 1, RST_HOLD, STAGE_GAP);
    localparam int SEQ_W    = $clog2(LAST_CYC + 1) + 1;

    if (NCH < 1 || NCH > NCH_MAX) begin : g_bad_nch
        $error("clken_rst_seq: NCH out of range");
    end
    if (RST_HOLD < 1) begin : g_bad_hold
        $error("clken_rst_seq: RST_HOLD must be at least 1");
    end
    if (PERIOD_CNT < 0 || longint'(PERIOD_CNT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_period
        $error("clken_rst_seq: PERIOD_CNT does not fit in CNT_W");
    end

    seq_state_t       state_q, state_d;
    logic [SEQ_W-1:0] cyc_q,   cyc_d;
    logic [NCH-1:0]   rel_q,   rel_d;
    logic             busy_q,  busy_d;
    logic [NCH-1:0]   rel_pulse;

    // cyc_d is the number of the edge being evaluated (1 = first edge after
    // reset), so a channel releases on the edge whose number matches its
    // stage cycle. Per-channel compares handle STAGE_GAP == 0 and NCH == 1,
    // where several releases (or the final one) land on the hold edge.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        rel_d     = rel_q;
        busy_d    = busy_q;
        rel_pulse = '0;
        if (state_q != S_RUN) begin
            cyc_d = cyc_q + SEQ_W'(1);
            for (int i = 0; i < NCH; i++) begin
                if (!rel_q[i] && cyc_d == SEQ_W'(stage_cycle(i, RST_HOLD, STAGE_GAP))) begin
                    rel_pulse[i] = 1'b1;
                end
            end
            rel_d = rel_q | rel_pulse;
            if (&rel_d) begin
                state_d = S_RUN;
                busy_d  = 1'b0;
            end else if (rel_d[0]) begin
                state_d = S_STAGE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst_x) begin
            state_q <= S_HOLD;
            cyc_q   <= '0;
            rel_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            rel_q   <= rel_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clken_div_chan #(
            .CNT_W      (CNT_W),
            .PERIOD_CNT (PERIOD_CNT)
        ) u_chan (
            .clock        (clock),
            .rst_x        (rst_x),
            .chan_release (rel_pulse[g]),
            .pause        (pause),
            .div          (cfg_div[g*CNT_W +: CNT_W]),
            .ce           (ch_ce[g]),
            .done         (ch_done[g])
        );
    end

    // rel_q is 1 once released; map to the requested asserted level.
    assign ch_rst   = (ACTIVE != 0) ? ~rel_q : rel_q;
    assign seq_busy = busy_q;
    assign done     = (PERIOD_CNT != 0) && (&ch_done);

endmodule

// File: tb/tb_clken_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_clken_rst_seq
//   Three instances sharing clock and rst_x:
//     A: NCH=4, RST_HOLD=5, STAGE_GAP=2, unlimited pulses, active-high resets,
//        mixed divide ratios (3, 0, 1, 5), pause exercised.
//     B: same sequencing, PERIOD_CNT=4, all ratios 2.
//     C: NCH=1, RST_HOLD=3, active-low reset, ratio 2.
//   Expected waveforms are hand-written per-cycle bit masks.
// ---------------------------------------------------------------------------
module tb_clken_rst_seq;

    logic clk;
    logic rst_x;
    logic pause_a;
    logic pause_0;

    logic [63:0] a_cfg;
    logic [63:0] b_cfg;
    logic [15:0] c_cfg;

    logic [3:0] a_rst, a_ce, a_cdone;
    logic       a_busy, a_done;
    logic [3:0] b_rst, b_ce, b_cdone;
    logic       b_busy, b_done;
    logic [0:0] c_rst, c_ce, c_cdone;
    logic       c_busy, c_done;

    int n_chk;
    int n_err;

    clken_rst_seq #(.NCH(4), .CNT_W(16), .RST_HOLD(5), .STAGE_GAP(2),
                    .PERIOD_CNT(0), .ACTIVE(1)) u_a (
        .clock(clk), .rst_x(rst_x), .pause(pause_a), .cfg_div(a_cfg),
        .ch_rst(a_rst), .ch_ce(a_ce), .ch_done(a_cdone),
        .seq_busy(a_busy), .done(a_done));

    clken_rst_seq #(.NCH(4), .CNT_W(16), .RST_HOLD(5), .STAGE_GAP(2),
                    .PERIOD_CNT(4), .ACTIVE(1)) u_b (
        .clock(clk), .rst_x(rst_x), .pause(pause_0), .cfg_div(b_cfg),
        .ch_rst(b_rst), .ch_ce(b_ce), .ch_done(b_cdone),
        .seq_busy(b_busy), .done(b_done));

    clken_rst_seq #(.NCH(1), .CNT_W(16), .RST_HOLD(3), .STAGE_GAP(2),
                    .PERIOD_CNT(0), .ACTIVE(0)) u_c (
        .clock(clk), .rst_x(rst_x), .pause(pause_0), .cfg_div(c_cfg),
        .ch_rst(c_rst), .ch_ce(c_ce), .ch_done(c_cdone),
        .seq_busy(c_busy), .done(c_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Release cycles 5,7,9,11 for A and B.
    localparam int REL [4] = '{5, 7, 9, 11};

    // A, first run: ch0 D=3 (11 paused -> 13), ch1 D=0 and ch2 D=1 every
    // cycle except paused 11,12, ch3 D=5 released on a paused edge.
    localparam logic [31:0] A1_CE0 = (32'd1 << 8) | (32'd1 << 13) | (32'd1 << 16) |
                                     (32'd1 << 19) | (32'd1 << 22) | (32'd1 << 25);
    localparam logic [31:0] A1_CE1 = ~((32'd1 << 8) - 32'd1) & ~(32'd3 << 11);
    localparam logic [31:0] A1_CE2 = ~((32'd1 << 10) - 32'd1) & ~(32'd3 << 11);
    localparam logic [31:0] A1_CE3 = (32'd1 << 17) | (32'd1 << 22);
    // A, later runs: ch0 relatched D=7 -> first pulse 12, no pause.
    localparam logic [31:0] A2_CE0 = (32'd1 << 12);
    localparam logic [31:0] A2_CE1 = ~((32'd1 << 8) - 32'd1);
    localparam logic [31:0] A2_CE2 = ~((32'd1 << 10) - 32'd1);
    localparam logic [31:0] A2_CE3 = 32'd0;
    // B: four pulses per channel, spaced 2.
    localparam logic [31:0] B_CE0 = (32'd1 << 7)  | (32'd1 << 9)  | (32'd1 << 11) | (32'd1 << 13);
    localparam logic [31:0] B_CE1 = (32'd1 << 9)  | (32'd1 << 11) | (32'd1 << 13) | (32'd1 << 15);
    localparam logic [31:0] B_CE2 = (32'd1 << 11) | (32'd1 << 13) | (32'd1 << 15) | (32'd1 << 17);
    localparam logic [31:0] B_CE3 = (32'd1 << 13) | (32'd1 << 15) | (32'd1 << 17) | (32'd1 << 19);
    localparam int B_DONE [4] = '{13, 15, 17, 19};
    // C: released at 3, D=2 -> pulses on odd cycles from 5.
    localparam logic [31:0] C_CE = 32'hAAAA_AAA0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " a_rst"},  {28'd0, a_rst},   32'hF);
        chk({tag, " a_ce"},   {28'd0, a_ce},    32'h0);
        chk({tag, " a_busy"}, {31'd0, a_busy},  32'h1);
        chk({tag, " b_rst"},  {28'd0, b_rst},   32'hF);
        chk({tag, " b_ce"},   {28'd0, b_ce},    32'h0);
        chk({tag, " b_cdone"},{28'd0, b_cdone}, 32'h0);
        chk({tag, " b_done"}, {31'd0, b_done},  32'h0);
        chk({tag, " c_rst"},  {31'd0, c_rst},   32'h0);
        chk({tag, " c_ce"},   {31'd0, c_ce},    32'h0);
        chk({tag, " c_busy"}, {31'd0, c_busy},  32'h1);
    endtask

    task automatic check_cycle(input int c, input bit later_run);
        logic [3:0]  e_rst, e_ace, e_bce, e_bdone;
        logic [31:0] am [4];
        logic [31:0] bm [4];
        if (later_run) begin
            am = '{A2_CE0, A2_CE1, A2_CE2, A2_CE3};
        end else begin
            am = '{A1_CE0, A1_CE1, A1_CE2, A1_CE3};
        end
        bm = '{B_CE0, B_CE1, B_CE2, B_CE3};
        for (int i = 0; i < 4; i++) begin
            e_rst[i]   = (c < REL[i]);
            e_ace[i]   = am[i][c];
            e_bce[i]   = bm[i][c];
            e_bdone[i] = (c >= B_DONE[i]);
        end
        chk($sformatf("c%0d a_rst", c),   {28'd0, a_rst},   {28'd0, e_rst});
        chk($sformatf("c%0d a_busy", c),  {31'd0, a_busy},  {31'd0, (c < 11)});
        chk($sformatf("c%0d a_ce", c),    {28'd0, a_ce},    {28'd0, e_ace});
        chk($sformatf("c%0d a_cdone", c), {27'd0, a_cdone, a_done}, 32'd0);
        chk($sformatf("c%0d b_rst", c),   {28'd0, b_rst},   {28'd0, e_rst});
        chk($sformatf("c%0d b_busy", c),  {31'd0, b_busy},  {31'd0, (c < 11)});
        chk($sformatf("c%0d b_ce", c),    {28'd0, b_ce},    {28'd0, e_bce});
        chk($sformatf("c%0d b_cdone", c), {28'd0, b_cdone}, {28'd0, e_bdone});
        chk($sformatf("c%0d b_done", c),  {31'd0, b_done},  {31'd0, (c >= 19)});
        chk($sformatf("c%0d c_rst", c),   {31'd0, c_rst},   {31'd0, (c >= 3)});
        chk($sformatf("c%0d c_busy", c),  {31'd0, c_busy},  {31'd0, (c < 3)});
        chk($sformatf("c%0d c_ce", c),    {31'd0, c_ce},    {31'd0, C_CE[c]});
        chk($sformatf("c%0d c_cdone", c), {30'd0, c_cdone, c_done}, 32'd0);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_x   = 1'b1;
        pause_a = 1'b0;
        pause_0 = 1'b0;
        a_cfg   = {16'd5, 16'd1, 16'd0, 16'd3};
        b_cfg   = {16'd2, 16'd2, 16'd2, 16'd2};
        c_cfg   = 16'd2;

        repeat (2) @(posedge clk);
        #1;
        check_reset("init");
        rst_x = 1'b0;

        // First run: pause covers edges 11 and 12; ch0 ratio change after
        // its release must be ignored.
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk);
            #1;
            check_cycle(c, 1'b0);
            if (c == 9)  a_cfg[15:0] = 16'd7;
            if (c == 10) pause_a = 1'b1;
            if (c == 12) pause_a = 1'b0;
        end

        // Fresh reset, then abort the sequence mid-stage at cycle 8.
        rst_x = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst2");
        rst_x = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            check_cycle(c, 1'b1);
        end
        rst_x = 1'b1;
        @(posedge clk);
        #1;
        check_reset("mid");
        rst_x = 1'b0;

        // Sequence restarts from cycle 1; ch0 relatches ratio 7.
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            check_cycle(c, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
